seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Parametrised N-digit multiplexed 7-segment display driver, replacing the fixed 4-digit scan logic in the top level.
- Accepts a packed hex-nibble bus through a tear-free load handshake and scans digits at a programmable rate.
- Supports per-digit blink (edit cursor) and per-digit decimal point.
- Sits between the service blocks (time set, alarm set, stopwatch, alarm game) and the board's anode/segment pins.

Parameters:
- DIGITS, 4: number of digits scanned; legal range 2..8.
- SCAN_DIV, 65536: clk cycles each digit stays lit; must be >= 2.
- BLINK_DIV, 16777216: clk cycles per blink half-period; must be >= 2.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- en  input  1  display enable; 0 blanks the display and holds the scan at digit 0.
- load  input  1  single-cycle strobe; captures digits_in, blink_mask and dp_mask.
- digits_in  input  4*DIGITS  packed nibbles; [3:0] is the rightmost digit (index 0).
- blink_mask  input  DIGITS  1 = digit blinks.
- dp_mask  input  DIGITS  1 = decimal point lit on that digit.
- anode  output  DIGITS  active-low digit select, registered.
- seg  output  7  active-high segments {g,f,e,d,c,b,a}, registered.
- dp  output  1  active-high decimal point, registered.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

Behaviour:
- Reset (async, resetn=0):
  - anode = all 1s; seg = 0; dp = 0; frame_done = 0.
  - Prescaler = 0, digit index = 0, blink counter = 0, blink_phase = 0.
  - Staging and display registers = 0; pending = 0.
- Load handshake:
  - load=1 copies digits_in/blink_mask/dp_mask into staging and sets pending.
  - Staging is copied to display only on a wrap cycle with pending=1; pending then clears.
  - A mid-frame load never alters the digits shown in the current frame.
  - Multiple loads within one frame: the last one wins.
  - load on the wrap cycle itself: display takes the old staging, staging takes the new data, pending stays 1 (new data shows next frame).
  - With en=0 and pending=1, display updates on the next cycle without waiting for a wrap.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it returns to 0 and the index advances.
  - Index wraps from DIGITS-1 to 0; frame_done=1 on exactly that cycle.
  - Outputs have 1-cycle latency: anode/seg/dp reflect the index of the previous cycle.
  - anode[i] = 0 only for the current index i, with one exception: if blink_mask[i]=1 and blink_phase=1, anode is all 1s for that slot.
- Blink: the blink counter counts 0..BLINK_DIV-1 and toggles blink_phase at terminal count. It runs independently of en.
- Decode (full hex):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- dp = dp_mask[index] of the display register.
- en=0:
  - anode = all 1s, seg = 0, dp = 0, frame_done = 0.
  - Prescaler and index are held at 0.
  - When en rises, scanning restarts at digit 0 with the full SCAN_DIV dwell.
- Reset mid-frame discards staging and pending data.

Optional Feature:
- Macro SEG_SCAN_LZB_EN: leading-zero blanking.
- With the macro defined: any display digit that is 0 and has all higher-index digits also 0 is blanked (seg=0, anode still driven low). Digit 0 is never blanked. dp still follows dp_mask. The decision uses the display register, so it is tear-free.
- Without the macro: zeros always show as "0".

Test Plan (DIGITS=4, SCAN_DIV=4, BLINK_DIV=32):
- Reset release, en=1, no load -> anode sequence 1110,1101,1011,0111 with 4 cycles per digit, seg=0111111 throughout; frame_done pulses every 16 cycles.
- load digits_in=16'h12AF mid-frame -> current frame unchanged; next frame shows seg 1110001 (F), 1110111 (A), 1011011 (2), 0000110 (1) on digits 0..3.
- load on the wrap cycle, then a second load 5 cycles later with 16'h0003 -> the first value is skipped and 0003 appears at the following wrap.
- blink_mask=4'b0010 -> digit 1 anode stays 1 throughout each 32-cycle phase-1 window and is lit during phase-0 windows; other digits are unaffected.
- en dropped mid-scan at index 2 -> anode=1111 and seg=0 from the next cycle; en re-raised -> first lit anode is 1110, held 4 cycles.
- With SEG_SCAN_LZB_EN defined and 16'h0050 loaded -> digits 3 and 2 have seg=0, digit 1 shows 5, digit 0 shows 0; loading 16'h0000 shows only digit 0 as "0".

Source files
------------

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: N-digit multiplexed 7-segment scanner with tear-free load, per-digit blink and dp.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_mux #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 65536,
    parameter int BLINK_DIV = 16777216
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] digits_in,
    input  logic [DIGITS-1:0]   blink_mask,
    input  logic [DIGITS-1:0]   dp_mask,
    output logic [DIGITS-1:0]   anode,
    output logic [6:0]          seg,
    output logic                dp,
    output logic                frame_done
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [6:0] HEX7 [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [4*DIGITS-1:0] stg_dig_q, stg_dig_d, disp_dig_q, disp_dig_d;
    logic [DIGITS-1:0]   stg_blink_q, stg_blink_d, disp_blink_q, disp_blink_d;
    logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
    logic                pending_q, pending_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                scan_tc, last_idx, blink_tc, wrap, upd, blank;
    logic [3:0]          nib;

    // Display only changes on a frame boundary, or immediately while blanked.
    always_comb begin
        scan_tc       = presc_q == PW'(SCAN_DIV - 1);
        last_idx      = idx_q == IW'(DIGITS - 1);
        blink_tc      = blink_cnt_q == BW'(BLINK_DIV - 1);
        wrap          = en && scan_tc && last_idx;
        upd           = pending_q && (wrap || !en);
        presc_d       = (!en || scan_tc) ? '0 : presc_q + 1'b1;
        idx_d         = !en ? '0 : !scan_tc ? idx_q : last_idx ? '0 : idx_q + 1'b1;
        blink_cnt_d   = blink_tc ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_tc;
        stg_dig_d     = load ? digits_in : stg_dig_q;
        stg_blink_d   = load ? blink_mask : stg_blink_q;
        stg_dp_d      = load ? dp_mask : stg_dp_q;
        pending_d     = load || (pending_q && !upd);
        disp_dig_d    = upd ? stg_dig_q : disp_dig_q;
        disp_blink_d  = upd ? stg_blink_q : disp_blink_q;
        disp_dp_d     = upd ? stg_dp_q : disp_dp_q;
    end

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] lz;
    always_comb begin
        lz[DIGITS-1] = disp_dig_q[4*DIGITS-1 -: 4] == 4'd0;
        for (int i = DIGITS - 2; i >= 0; i--)
            lz[i] = lz[i+1] && disp_dig_q[4*i +: 4] == 4'd0;
    end
    assign blank = lz[idx_q] && idx_q != '0;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        nib     = disp_dig_q[{idx_q, 2'b00} +: 4];
        anode_d = (!en || (disp_blink_q[idx_q] && blink_phase_q)) ? '1 : ~(DIGITS'(1) << idx_q);
        seg_d   = (!en || blank) ? 7'd0 : HEX7[nib];
        dp_d    = en && disp_dp_q[idx_q];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q       <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            stg_dig_q     <= '0;
            stg_blink_q   <= '0;
            stg_dp_q      <= '0;
            disp_dig_q    <= '0;
            disp_blink_q  <= '0;
            disp_dp_q     <= '0;
            pending_q     <= 1'b0;
            anode_q       <= '1;
            seg_q         <= '0;
            dp_q          <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            stg_dig_q     <= stg_dig_d;
            stg_blink_q   <= stg_blink_d;
            stg_dp_q      <= stg_dp_d;
            disp_dig_q    <= disp_dig_d;
            disp_blink_q  <= disp_blink_d;
            disp_dp_q     <= disp_dp_d;
            pending_q     <= pending_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = wrap;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed bench for seg_scan_mux (DIGITS=4, SCAN_DIV=4, BLINK_DIV=32).
// Expectations follow SEG_SCAN_LZB_EN when the bench is built with that macro.
module tb_seg_scan_mux;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(32)) dut (
        .clk(clk), .resetn(resetn), .en(en), .load(load), .digits_in(digits_in),
        .blink_mask(blink_mask), .dp_mask(dp_mask), .anode(anode), .seg(seg),
        .dp(dp), .frame_done(frame_done)
    );

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0111111;  4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;  4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;  4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;  4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1101111;
            4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b1111100;
            4'hC: hex7 = 7'b0111001;  4'hD: hex7 = 7'b1011110;
            4'hE: hex7 = 7'b1111001;  default: hex7 = 7'b1110001;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        exp_seg = hex7(v[d*4 +: 4]);
`ifdef SEG_SCAN_LZB_EN
        if (d > 0 && (v >> (4 * d)) == 16'd0) exp_seg = 7'd0;
`endif
    endfunction

    function automatic logic [3:0] exp_an(input int d);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << d;
        exp_an = ~one_hot;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] dm);
        digits_in = v;
        blink_mask = bm;
        dp_mask = dm;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_wrap();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 64);
        if (!frame_done) chk("wrap_timeout", frame_done, 1);
    endtask

    // Called on the negedge where frame_done is high; checks the whole next frame.
    task automatic show_frame(input string tag, input logic [15:0] v, input logic [3:0] dm);
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk({tag, "_an"}, anode, exp_an(c / 4));
            chk({tag, "_seg"}, seg, exp_seg(v, c / 4));
            chk({tag, "_dp"}, dp, dm[c/4]);
            chk({tag, "_fd"}, frame_done, c == 14);
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] dm);
        wait_wrap();
        show_frame(tag, v, dm);
    endtask

    initial begin
        int lit, dark, d0;
        repeat (3) @(negedge clk);
        chk("rst_an", anode, 4'b1111);
        chk("rst_seg", seg, 7'd0);
        chk("rst_dp", dp, 1'b0);
        chk("rst_fd", frame_done, 1'b0);
        resetn = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk("scan_an", anode, exp_an(((k - 1) / 4) % 4));
            chk("scan_seg", seg, exp_seg(16'h0000, ((k - 1) / 4) % 4));
            chk("scan_fd", frame_done, k % 16 == 15);
        end
        repeat (5) @(negedge clk);
        do_load(16'h12AF, 4'b0000, 4'b0000);
        for (int k = 39; k <= 47; k++) begin
            @(negedge clk);
            chk("hold_seg", seg, exp_seg(16'h0000, ((k - 1) / 4) % 4));
        end
        chk("hold_fd", frame_done, 1'b1);
        show_frame("f12af", 16'h12AF, 4'b0000);
        wait_wrap();
        do_load(16'h4567, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("wrapld_seg", seg, 7'b1110001);
        repeat (3) @(negedge clk);
        do_load(16'h0003, 4'b0000, 4'b0000);
        check_frame("f0003", 16'h0003, 4'b0000);
        wait_wrap();
        do_load(16'hC0DE, 4'b0000, 4'b0101);
        check_frame("fc0de", 16'hC0DE, 4'b0101);
        do_load(16'h12AF, 4'b0010, 4'b0000);
        repeat (40) @(negedge clk);
        lit = 0;
        dark = 0;
        d0 = 0;
        repeat (128) begin
            @(negedge clk);
            if (anode == 4'b1101) lit++;
            else if (anode == 4'b1111) dark++;
            else if (anode == 4'b1110) d0++;
        end
        chk("blink_lit", lit, 16);
        chk("blink_dark", dark, 16);
        chk("blink_d0", d0, 32);
        do_load(16'h12AF, 4'b0000, 4'b0000);
        wait_wrap();
        repeat (11) @(negedge clk);
        chk("pre_drop_an", anode, 4'b1011);
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("off_an", anode, 4'b1111);
            chk("off_seg", seg, 7'd0);
            chk("off_dp", dp, 1'b0);
            chk("off_fd", frame_done, 1'b0);
        end
        do_load(16'h9876, 4'b0000, 4'b0001);
        @(negedge clk);
        chk("off_ld_an", anode, 4'b1111);
        en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("on_an", anode, 4'b1110);
            chk("on_seg", seg, 7'b1111101);
            chk("on_dp", dp, 1'b1);
        end
        @(negedge clk);
        chk("on_an1", anode, 4'b1101);
        chk("on_seg1", seg, 7'b0000111);
        chk("on_dp1", dp, 1'b0);
        do_load(16'h5555, 4'b0000, 4'b1111);
        resetn = 1'b0;
        #1;
        chk("arst_an", anode, 4'b1111);
        chk("arst_seg", seg, 7'd0);
        @(negedge clk);
        resetn = 1'b1;
        check_frame("rst0", 16'h0000, 4'b0000);
        check_frame("rst1", 16'h0000, 4'b0000);
        do_load(16'h0050, 4'b0000, 4'b0010);
        check_frame("f0050", 16'h0050, 4'b0010);
        do_load(16'h0000, 4'b0000, 4'b0000);
        check_frame("f0000", 16'h0000, 4'b0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
